// File: rtl/spi_reg_bank_rw_if.sv
// SPI pad-side signal bundle for the register bank.
interface spi_reg_bank_rw_if;
  logic sclk_in;
  logic ncs_in;
  logic copi_in;
  logic cipo_out;
  logic cipo_oe;

  modport master (output sclk_in, ncs_in, copi_in, input cipo_out, cipo_oe);
  modport slave  (input sclk_in, ncs_in, copi_in, output cipo_out, cipo_oe);
endinterface

// File: rtl/spi_reg_bank_rw.sv
// SPI-slave register bank: oversampled SPI frames write registers, read back on CIPO,
// and malformed frames are counted.
module spi_reg_bank_rw #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_reg_bank_rw_if.slave           spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [7:0]                 err_count
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0]  CNT_FRAME  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_OVER   = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_CMD    = CNT_W'(1 + ADDR_W);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, OVERRUN} state_t;
  state_t state_q, state_d;

  // Chains reset to 0 so a frame already in progress at reset release holds us in WAIT_IDLE.
  logic [SYNC_STAGES-1:0] ncs_sync, copi_sync;
  logic [SYNC_STAGES:0]   sclk_sync;
  logic                   ncs_prev, sclk_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync  <= '0;
      copi_sync <= '0;
      sclk_sync <= '0;
      ncs_prev  <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-1:0], spi.sclk_in};
      ncs_prev  <= ncs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES];
    end
  end

  logic ncs_s, copi_s, ncs_fall, ncs_rise, sclk_rise, sclk_fall;
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_fall  = ncs_prev & ~ncs_s;
  assign ncs_rise  = ~ncs_prev & ncs_s;
  assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES];
  assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES];

  logic [CNT_W-1:0]     bit_cnt, cnt_inc;
  logic [FRAME_LEN-1:0] rx;
  logic [DATA_W-1:0]    tx;
  assign cnt_inc = bit_cnt + CNT_W'(1);

  // Command word as it stands after the current rising edge is shifted in.
  logic [ADDR_W:0]   cmd;
  logic [ADDR_W-1:0] cmd_addr, f_addr;
  logic              cmd_rw, cmd_addr_ok, f_rw, f_addr_ok;
  logic [DATA_W-1:0] f_data, rd_word;
  assign cmd         = {rx[ADDR_W-1:0], copi_s};
  assign cmd_rw      = cmd[ADDR_W];
  assign cmd_addr    = cmd[ADDR_W-1:0];
  assign cmd_addr_ok = {1'b0, cmd_addr} < NUM_REGS_A;
  assign f_rw        = rx[FRAME_LEN-1];
  assign f_addr      = rx[FRAME_LEN-2 -: ADDR_W];
  assign f_data      = rx[DATA_W-1:0];
  assign f_addr_ok   = {1'b0, f_addr} < NUM_REGS_A;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if ({1'b0, cmd_addr} == (ADDR_W+1)'(i)) rd_word = regs_out[i*DATA_W +: DATA_W];
  end

  logic shift_en, commit;

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (ncs_s) state_d = IDLE;
      IDLE:      if (ncs_fall) state_d = SHIFT;
      SHIFT: begin
        if (ncs_rise) begin
          state_d = IDLE;
          commit  = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (cnt_inc == CNT_OVER) state_d = OVERRUN;
        end
      end
      OVERRUN: begin
        if (ncs_rise) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  logic frame_ok, frame_empty;
  assign frame_ok    = (state_q == SHIFT) && (bit_cnt == CNT_FRAME);
  assign frame_empty = (state_q == SHIFT) && (bit_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      regs_out  <= RESET_VALS;
      wr_strobe <= '0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      wr_strobe <= '0;
      if (state_q == IDLE && ncs_fall) begin
        bit_cnt <= '0;
        rx      <= '0;
        tx      <= '0;
      end
      if (shift_en) begin
        rx      <= {rx[FRAME_LEN-2:0], copi_s};
        bit_cnt <= cnt_inc;
        if (cnt_inc == CNT_CMD) tx <= (!cmd_rw && cmd_addr_ok) ? rd_word : '0;
      end else if (state_q == SHIFT && !ncs_rise && sclk_fall && bit_cnt > CNT_CMD) begin
        tx <= {tx[DATA_W-2:0], 1'b0};
      end
      if (commit) begin
        if (frame_ok) begin
          if (f_rw && f_addr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if ({1'b0, f_addr} == (ADDR_W+1)'(i)) begin
                regs_out[i*DATA_W +: DATA_W] <= f_data;
                wr_strobe[i]                 <= 1'b1;
              end
            end
          end
        end else if (!frame_empty && err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

  assign spi.cipo_out = (state_q == SHIFT) ? tx[DATA_W-1] : 1'b0;
  assign spi.cipo_oe  = (state_q == SHIFT) || (state_q == OVERRUN);
endmodule

// File: tb/tb_spi_reg_bank_rw.sv
// Self-checking bench for spi_reg_bank_rw: table of SPI frames with a strobe scoreboard.
module tb_spi_reg_bank_rw;
  localparam logic [39:0] RV = 40'h1122334455;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_reg_bank_rw_if spi();
  logic [39:0] regs_out;
  logic [4:0]  wr_strobe;
  logic [7:0]  err_count;

  spi_reg_bank_rw #(
    .ADDR_W(7), .DATA_W(8), .NUM_REGS(5), .SYNC_STAGES(2), .RESET_VALS(RV)
  ) dut (
    .clk(clk), .rst(rst), .spi(spi.slave),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .err_count(err_count)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [39:0] regs;
    logic [4:0]  strobe;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] bits;
    int          n;
    bit          mode3;
    logic [4:0]  exp_strobe;
    bit          rd_chk;
    logic [7:0]  exp_rd;
  } vec_t;

  logic [39:0] m_regs;
  int          m_err;

  // Strobe monitor: every strobe must match the scoreboard head and last one cycle.
  logic [4:0] prev_strobe = '0;
  always @(negedge clk) begin : mon
    sb_t e;
    if (rst) begin
      prev_strobe <= '0;
    end else begin
      if (prev_strobe != '0) check("strobe_width", wr_strobe, 0);
      else if (wr_strobe != '0) begin
        if (sb_q.size() == 0) check("unexpected_strobe", wr_strobe, 0);
        else begin
          e = sb_q.pop_front();
          check("strobe", wr_strobe, e.strobe);
          check("regs_at_strobe", regs_out, e.regs);
        end
      end
      prev_strobe <= wr_strobe;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Controller model: copi changes with falling sclk, cipo sampled just before each rising edge.
  task automatic do_frame(input logic [31:0] bits, input int n, input bit mode3,
                          input int rst_at, output logic [31:0] rd, output logic oe_all);
    rd = '0;
    oe_all = 1'b1;
    spi.sclk_in = mode3;
    repeat (8) @(negedge clk);
    spi.ncs_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (4) @(negedge clk);
      spi.sclk_in = 1'b0;
      spi.copi_in = bits[n-1-i];
      repeat (4) @(negedge clk);
      rd = {rd[30:0], spi.cipo_out};
      oe_all = oe_all & spi.cipo_oe;
      spi.sclk_in = 1'b1;
      if (i == rst_at) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    spi.sclk_in = mode3;
    repeat (4) @(negedge clk);
    spi.ncs_in  = 1'b1;
    spi.copi_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic settle_and_check(input string tag);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check({tag, "_sb_drain"}, sb_q.size(), 0);
    sb_q.delete();
    check({tag, "_regs"}, regs_out, m_regs);
    check({tag, "_err"}, err_count, m_err);
    check({tag, "_oe_idle"}, spi.cipo_oe, 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] rd;
    logic        oe;
    logic [6:0]  a;
    if (v.n == 16) begin
      a = v.bits[14:8];
      if (v.bits[15] && a < 7'd5) begin
        m_regs[int'(a)*8 +: 8] = v.bits[7:0];
        sb_q.push_back('{m_regs, v.exp_strobe});
      end
    end else if (v.n != 0) begin
      m_err = (m_err == 255) ? 255 : m_err + 1;
    end
    do_frame(v.bits, v.n, v.mode3, -1, rd, oe);
    settle_and_check(tag);
    if (v.n > 0) check({tag, "_oe_busy"}, oe, 1);
    if (v.rd_chk) check({tag, "_rd"}, rd[7:0], v.exp_rd);
  endtask

  vec_t vecs [18];

  initial begin
    logic [31:0] rd;
    logic        oe;
    vecs = '{
      '{32'h82A5,   16, 1'b0, 5'b00100, 1'b0, 8'h00},
      '{32'h0200,   16, 1'b0, 5'b00000, 1'b1, 8'hA5},
      '{32'h4155,   15, 1'b0, 5'b00000, 1'b0, 8'h00},
      '{32'h1F0F0,  17, 1'b0, 5'b00000, 1'b0, 8'h00},
      '{32'h8F12,   16, 1'b0, 5'b00000, 1'b0, 8'h00},
      '{32'h0F00,   16, 1'b0, 5'b00000, 1'b1, 8'h00},
      '{32'h0000,   16, 1'b0, 5'b00000, 1'b1, 8'h55},
      '{32'h0000,    0, 1'b0, 5'b00000, 1'b0, 8'h00},
      '{32'h80FF,   16, 1'b1, 5'b00001, 1'b0, 8'h00},
      '{32'h81FF,   16, 1'b1, 5'b00010, 1'b0, 8'h00},
      '{32'h82FF,   16, 1'b1, 5'b00100, 1'b0, 8'h00},
      '{32'h83FF,   16, 1'b1, 5'b01000, 1'b0, 8'h00},
      '{32'h84FF,   16, 1'b1, 5'b10000, 1'b0, 8'h00},
      '{32'h0000,   16, 1'b1, 5'b00000, 1'b1, 8'hFF},
      '{32'h0100,   16, 1'b1, 5'b00000, 1'b1, 8'hFF},
      '{32'h0200,   16, 1'b1, 5'b00000, 1'b1, 8'hFF},
      '{32'h0300,   16, 1'b1, 5'b00000, 1'b1, 8'hFF},
      '{32'h0400,   16, 1'b1, 5'b00000, 1'b1, 8'hFF}
    };

    spi.sclk_in = 1'b0;
    spi.ncs_in  = 1'b1;
    spi.copi_in = 1'b0;
    m_regs = RV;
    m_err  = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_regs", regs_out, RV);
    check("rst_err", err_count, 0);
    check("rst_oe", spi.cipo_oe, 0);
    check("rst_cipo", spi.cipo_out, 0);
    check("rst_strobe", wr_strobe, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 18; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Short frames drive the error counter into saturation.
    for (int i = 0; i < 260; i++) begin
      do_frame(32'h1, 1, 1'b0, -1, rd, oe);
      m_err = (m_err == 255) ? 255 : m_err + 1;
    end
    settle_and_check("saturate");
    check("err_sat", err_count, 8'hFF);

    rst = 1'b1;
    m_regs = RV;
    m_err  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst2_err", err_count, 0);

    // Reset lands mid-frame; the tail of that frame must be discarded silently.
    do_frame(32'h8133, 16, 1'b0, 9, rd, oe);
    settle_and_check("midrst");
    check("midrst_reg1", regs_out[15:8], 8'h44);
    apply('{32'h8133, 16, 1'b0, 5'b00010, 1'b0, 8'h00}, "after_midrst");
    check("after_midrst_reg1", regs_out[15:8], 8'h33);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
